// File: rtl/alu_exec_pkg.sv
// Shared types and defaults for the ALU execute/writeback stage.
// Opcode and FSM state encodings live here so the top and any bench agree on them.
package alu_exec_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpSlt = 4'd5,
        OpSll = 4'd6,
        OpSrl = 4'd7,
        OpSra = 4'd8,
        OpMul = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } exec_state_e;

    // Ops 0-8 complete in a single cycle; everything else is MUL or illegal.
    function automatic logic is_single_cycle_op(input logic [3:0] code);
        return code <= 4'd8;
    endfunction

endpackage

// File: rtl/alu_exec_stage_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, XLEN iterations.
// done is high during the final iteration, with product already carrying its result.
module alu_exec_stage_seq_mul #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [XLEN-1:0] acc_next;

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done     = busy_q && (cnt_q == CW'(XLEN - 1));
    // Exposing the final accumulation lets the caller leave on the last iteration edge.
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage feeding the register file write port with a one-cycle pulse.
// Define ALU_EXEC_MUL_EN to build the iterative multiplier; otherwise op 9 is illegal.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   dst,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    output logic            rw,
    output logic            zero,
    output logic            err
);

    localparam int unsigned SHW = $clog2(XLEN);

    exec_state_e     state_q, state_d;
    logic [AW-1:0]   a3_q;
    logic [XLEN-1:0] wd3_q;
    logic            zero_q, rw_q, err_q;

    logic            wb_load;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   wb_addr;
    logic            err_d;
    logic            drop;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

`ifdef ALU_EXEC_MUL_EN
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;
    logic [AW-1:0]   dst_q;

    alu_exec_stage_seq_mul #(
        .XLEN (XLEN)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (RD1),
        .b       (RD2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q <= '0;
        end else if (mul_start) begin
            dst_q <= dst;
        end
    end
`endif

    assign shamt = RD2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(op))
            OpAdd:   alu_res = RD1 + RD2;
            OpSub:   alu_res = RD1 - RD2;
            OpAnd:   alu_res = RD1 & RD2;
            OpOr:    alu_res = RD1 | RD2;
            OpXor:   alu_res = RD1 ^ RD2;
            OpSlt:   alu_res = {{(XLEN - 1){1'b0}}, ($signed(RD1) < $signed(RD2))};
            OpSll:   alu_res = RD1 << shamt;
            OpSrl:   alu_res = RD1 >> shamt;
            OpSra:   alu_res = XLEN'($signed(RD1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wb_load = 1'b0;
        wb_data = alu_res;
        wb_addr = dst;
        err_d   = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        mul_start = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_single_cycle_op(op)) begin
                        wb_load = 1'b1;
                        state_d = WB;
`ifdef ALU_EXEC_MUL_EN
                    end else if (op == OpMul) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef ALU_EXEC_MUL_EN
            MUL: begin
                if (mul_done) begin
                    wb_load = 1'b1;
                    wb_data = mul_product;
                    wb_addr = dst_q;
                    state_d = WB;
                end
            end
`endif
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes to r0 still update WD3/A3 so the stage timing is unchanged, only rw is masked.
    assign drop = (DROP_R0 != 0) && (wb_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a3_q    <= '0;
            wd3_q   <= '0;
            zero_q  <= 1'b0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= wb_load && !drop;
            err_q   <= err_d;
            if (wb_load) begin
                a3_q   <= wb_addr;
                wd3_q  <= wb_data;
                zero_q <= (wb_data == '0);
            end
        end
    end

    assign in_ready = (state_q == IDLE);
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign zero     = zero_q;
    assign rw       = rw_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (default parameters, DROP_R0=1).
// MUL scenarios run only when ALU_EXEC_MUL_EN is defined; otherwise op 9 must raise err.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic [4:0]  dst = '0;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        rw, zero, err;

    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .RD1      (rd1),
        .RD2      (rd2),
        .dst      (dst),
        .A3       (a3),
        .WD3      (wd3),
        .rw       (rw),
        .zero     (zero),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Present one op for a single accept edge, then scramble the inputs; returns 1 after that edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        @(negedge clk);
        op = o; rd1 = a; rd2 = b; dst = d; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'd1; rd1 = 32'hDEAD_BEEF; rd2 = 32'h1234_5678; dst = 5'd31;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", rw); end
        checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got %0d want 0", a3); end
        checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3 got %h want 0", wd3); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [3:0]  v_op  [10];
        logic [31:0] v_a   [10];
        logic [31:0] v_b   [10];
        logic [31:0] v_exp [10];
        v_op = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8};
        v_a  = '{32'd3, 32'd0, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'hF0F0_FF00,
                 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000};
        v_b  = '{32'd3, 32'd1, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'h0FF0_F0F0,
                 32'd1, 32'hFFFF_FFFF, 32'h0000_003F, 32'd4, 32'd4};
        v_exp = '{32'd0, 32'hFFFF_FFFF, 32'h00F0_F000, 32'hFFF0_FFF0, 32'hFF00_0FF0,
                  32'd1, 32'd0, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000};

        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd5);
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL add_rw got %b want 1", rw); end
        checks++; if (a3 !== 5'd5) begin errors++; $display("FAIL add_a3 got %0d want 5", a3); end
        checks++; if (wd3 !== 32'h8000_0000) begin errors++; $display("FAIL add_wd3 got %h want 80000000", wd3); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b want 0", zero); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_ready_in_wb got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL add_rw_pulse got %b want 0", rw); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready_after got %b want 1", in_ready); end
        checks++; if (wd3 !== 32'h8000_0000) begin errors++; $display("FAIL add_wd3_hold got %h want 80000000", wd3); end

        for (int i = 0; i < 10; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 5'(i + 1));
            checks++; if (rw !== 1'b1) begin errors++; $display("FAIL alu%0d_rw got %b want 1", i, rw); end
            checks++; if (a3 !== 5'(i + 1)) begin errors++; $display("FAIL alu%0d_a3 got %0d want %0d", i, a3, i + 1); end
            checks++; if (wd3 !== v_exp[i]) begin errors++; $display("FAIL alu%0d_wd3 got %h want %h", i, wd3, v_exp[i]); end
            checks++; if (zero !== (v_exp[i] == 32'd0)) begin errors++; $display("FAIL alu%0d_zero got %b want %b", i, zero, v_exp[i] == 32'd0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        issue(4'd0, 32'd10, 32'd20, 5'd3);
        // A new request during WB must be dropped, not queued.
        in_valid = 1'b1; op = 4'd0; rd1 = 32'd100; rd2 = 32'd1; dst = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL b2b_rw got %b want 0", rw); end
        checks++; if (a3 !== 5'd3) begin errors++; $display("FAIL b2b_a3 got %0d want 3", a3); end
        checks++; if (wd3 !== 32'd30) begin errors++; $display("FAIL b2b_wd3 got %0d want 30", wd3); end
        @(posedge clk); #1;
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL b2b_noqueue got %b want 0", rw); end
    endtask

    task automatic test_r0();
        issue(4'd0, 32'd7, 32'd8, 5'd0);
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL r0_rw got %b want 0", rw); end
        checks++; if (wd3 !== 32'd15) begin errors++; $display("FAIL r0_wd3 got %0d want 15", wd3); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL r0_in_wb got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL r0_rw_late got %b want 0", rw); end
    endtask

    task automatic test_illegal();
        issue(4'd12, 32'd1, 32'd2, 5'd6);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", err); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL ill_rw got %b want 0", rw); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse got %b want 0", err); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL ill_rw_late got %b want 0", rw); end
`ifndef ALU_EXEC_MUL_EN
        issue(4'd9, 32'd3, 32'd4, 5'd7);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nomul_err got %b want 1", err); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL nomul_rw got %b want 0", rw); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nomul_err_pulse got %b want 0", err); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL nomul_rw_late got %b want 0", rw); end
`endif
    endtask

`ifdef ALU_EXEC_MUL_EN
    task automatic test_mul();
        logic [31:0] m_a   [2];
        logic [31:0] m_b   [2];
        logic [31:0] m_exp [2];
        int cyc;
        int ready_bad;
        m_a   = '{32'd12345, 32'hFFFF_FFFF};
        m_b   = '{32'd678, 32'd2};
        m_exp = '{32'd8369910, 32'hFFFF_FFFE};
        for (int v = 0; v < 2; v++) begin
            issue(4'd9, m_a[v], m_b[v], 5'd7);
            checks++; if (rw !== 1'b0) begin errors++; $display("FAIL mul%0d_rw_early got %b want 0", v, rw); end
            // Cycle 1 is the cycle right after the accept edge (where an ALU op has rw high).
            in_valid = 1'b1; op = 4'd0; rd1 = 32'd1; rd2 = 32'd1; dst = 5'd2;
            cyc = 1;
            ready_bad = 0;
            while (cyc < 40 && rw !== 1'b1) begin
                if (in_ready !== 1'b0) ready_bad++;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0;
            checks++; if (cyc != 33) begin errors++; $display("FAIL mul%0d_latency got %0d want 33", v, cyc); end
            checks++; if (wd3 !== m_exp[v]) begin errors++; $display("FAIL mul%0d_wd3 got %h want %h", v, wd3, m_exp[v]); end
            checks++; if (a3 !== 5'd7) begin errors++; $display("FAIL mul%0d_a3 got %0d want 7", v, a3); end
            checks++; if (ready_bad != 0) begin errors++; $display("FAIL mul%0d_ready_busy got %0d want 0", v, ready_bad); end
            @(posedge clk); #1;
            checks++; if (rw !== 1'b0) begin errors++; $display("FAIL mul%0d_rw_pulse got %b want 0", v, rw); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul%0d_ready_after got %b want 1", v, in_ready); end
            @(posedge clk); #1;
            checks++; if (rw !== 1'b0) begin errors++; $display("FAIL mul%0d_noqueue got %b want 0", v, rw); end
        end
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        issue(4'd9, 32'd5, 32'd6, 5'd8);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL rmul_rw got %b want 0", rw); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmul_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        issue(4'd0, 32'd2, 32'd3, 5'd4);
        checks++; if (rw !== 1'b1) begin errors++; $display("FAIL rmul_add_rw got %b want 1", rw); end
        checks++; if (wd3 !== 32'd5) begin errors++; $display("FAIL rmul_add_wd3 got %0d want 5", wd3); end
        checks++; if (a3 !== 5'd4) begin errors++; $display("FAIL rmul_add_a3 got %0d want 4", a3); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rw === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmul_stale_write got %0d want 0", pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_r0();
        test_illegal();
`ifdef ALU_EXEC_MUL_EN
        test_mul();
        test_reset_mid_mul();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage directly downstream of reg_memory.
- Consumes the two register read operands (RD1, RD2) plus a decoded op and destination.
- Computes the result and drives reg_memory's write port (A3, WD3, rw) as a registered, single-cycle write pulse.
- Single-cycle ALU ops finish in 1 cycle. MUL uses an iterative shift-add engine and finishes in 33 cycles.

Parameters:
- XLEN, 32, operand/result width; must equal the reg_memory data width.
- AW, 5, register address width; must equal the reg_memory address width.
- DROP_R0, 1, when 1, results targeting register 0 are computed but rw is suppressed.

Ports:
- clk  input  1  rising-edge clock, shared with reg_memory.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  op/operands/dst valid this cycle.
- in_ready  output  1  stage can accept; high only in IDLE.
- op  input  4  operation code (see Behaviour).
- RD1  input  XLEN  operand A, from reg_memory RD1.
- RD2  input  XLEN  operand B, from reg_memory RD2.
- dst  input  AW  destination register index.
- A3  output  AW  write address to reg_memory.
- WD3  output  XLEN  write data to reg_memory.
- rw  output  1  write enable to reg_memory; one-cycle pulse.
- zero  output  1  WD3 == 0; valid while rw is high.
- err  output  1  one-cycle pulse for an illegal op.

Behaviour:
- Reset: all outputs 0 except in_ready=1; state=IDLE; multiplier registers cleared.
- Handshake: an op is accepted on a rising edge when in_valid && in_ready. RD1, RD2, op and dst are captured at acceptance; later input changes are ignored.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare; result 1 or 0.
  - 6 SLL, 7 SRL, 8 SRA: shift amount is RD2[4:0].
  - 9 MUL: low XLEN bits of the unsigned product.
  - 10-15: illegal.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- States:
  - IDLE: on accept of ops 0-8, go to WB with the result registered. On accept of op 9, go to MUL with cnt=0, acc=0, mcand=RD1, mplier=RD2. On accept of an illegal op, stay in IDLE and pulse err next cycle; rw stays 0.
  - MUL: each cycle, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. After the cnt==XLEN-1 iteration, go to WB.
  - WB: rw=1, A3=dst, WD3=result, zero=(result==0) for exactly one cycle; then return to IDLE.
- Latency, acceptance edge to rw high:
  - ALU ops: 1 cycle.
  - MUL: XLEN+1 cycles (33).
- Throughput: one op every 2 cycles for ALU ops, since in_ready is low during WB.
- Outputs outside WB: rw=0. A3, WD3 and zero hold their last values.
- DROP_R0=1 and dst==0: WB is still entered and WD3 updated, but rw stays 0.
- Reset mid-operation (MUL or WB): immediate abort on that edge; no write issued.
- in_valid while in_ready is low: ignored; no queuing.

Optional Feature:
- Macro ALU_EXEC_MUL_EN.
  - Defined: op 9 implemented as above.
  - Undefined: MUL state and registers are not built; op 9 is treated as illegal (err pulse, no rw); max latency is 1.

Decomposition:
- Package alu_exec_pkg holds:
  - typedef enum alu_op_e (4-bit codes above);
  - typedef enum exec_state_e {IDLE, MUL, WB};
  - constants XLEN_DEF=32, AW_DEF=5.
- Sub-module seq_mul: iterative shift-add multiplier with start/done, instantiated only under ALU_EXEC_MUL_EN.

Test Plan:
- Reset: rst=1 for 2 cycles -> in_ready=1, rw=0, A3=0, WD3=0, err=0.
- ADD: op=0, RD1=32'h7FFFFFFF, RD2=1, dst=5 -> next cycle rw=1, A3=5, WD3=32'h80000000, zero=0. SUB with RD1=RD2=3 -> WD3=0, zero=1.
- SRA/SLT: SRA RD1=32'h80000000, RD2=4 -> WD3=32'hF8000000. SLT RD1=-1, RD2=1 -> WD3=1.
- MUL: op=9, RD1=12345, RD2=678, dst=7 -> rw=1 exactly 33 cycles later with WD3=8369910. in_ready=0 and in_valid ignored throughout. MUL 32'hFFFFFFFF*2 -> WD3=32'hFFFFFFFE.
- r0 and illegal: ADD with dst=0 (DROP_R0=1) -> rw stays 0. op=12 -> err pulses once, no rw. With macro undefined, op=9 -> err.
- Reset mid-MUL: rst at cycle 10 of MUL -> no rw pulse, in_ready=1 the cycle after, and a following ADD completes normally.
